// File: rtl/sram_pkg.sv
// Shared types and constants for SRAM initiators and readers.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 13;
  localparam int unsigned SRAM_NUM_WMASKS = 4;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/sram_load_align.sv
// Aligns a 32-bit SRAM read word to a byte offset and sign/zero-extends
// the selected byte, half or word.
module sram_load_align
  import sram_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  mem_size_e   size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    shifted = word_i >> {offset_i, 3'b000};
    data_o  = shifted;
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/sram_lsu_master.sv
// Load/store initiator for the on-chip data SRAM: one outstanding request,
// single-cycle SRAM select, fixed read latency, one-cycle response strobe.
module sram_lsu_master
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = SRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_WMASKS   = SRAM_NUM_WMASKS,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH+1:0] req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [NUM_WMASKS-1:0] sram_wmask_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  lsu_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] off_q;
  mem_size_e  size_q;
  logic       uns_q, we_q;

  mem_size_e             req_size;
  logic                  req_err;
  logic [NUM_WMASKS-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] load_data;

  logic                  csb_d, web_d, rsp_valid_d, rsp_err_d;
  logic [NUM_WMASKS-1:0] wmask_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, rsp_rdata_d;

  assign req_ready_o = (state_q == IDLE);

  sram_load_align u_align (
    .word_i     (sram_rdata_i),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  // Decode the incoming request: alignment check and store lane replication.
  always_comb begin
    req_size  = mem_size_e'(req_size_i);
    req_err   = 1'b0;
    lane_mask = 4'b1111;
    lane_data = req_wdata_i;
    case (req_size)
      SZ_BYTE: begin
        lane_mask = 4'b0001 << req_addr_i[1:0];
        lane_data = {4{req_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        req_err   = req_addr_i[0];
        lane_mask = 4'b0011 << {req_addr_i[1], 1'b0};
        lane_data = {2{req_wdata_i[15:0]}};
      end
      SZ_WORD: req_err = |req_addr_i[1:0];
      default: req_err = 1'b1;
    endcase
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    wmask_d     = '0;
    addr_d      = sram_addr_o;
    wdata_d     = sram_wdata_o;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
            csb_d   = 1'b0;
            web_d   = ~req_we_i;
            addr_d  = req_addr_i[ADDR_WIDTH+1:2];
            wmask_d = req_we_i ? lane_mask : '0;
            wdata_d = lane_data;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 2'(READ_LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Registered outputs, wait counter and request fields latched at accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      off_q        <= '0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      sram_csb_o   <= 1'b1;
      sram_web_o   <= 1'b1;
      sram_wmask_o <= '0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_err_o    <= 1'b0;
      rsp_rdata_o  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      if (req_valid_i && req_ready_o) begin
        off_q  <= req_addr_i[1:0];
        size_q <= req_size;
        uns_q  <= req_unsigned_i;
        we_q   <= req_we_i;
      end
      sram_csb_o   <= csb_d;
      sram_web_o   <= web_d;
      sram_wmask_o <= wmask_d;
      sram_addr_o  <= addr_d;
      sram_wdata_o <= wdata_d;
      rsp_valid_o  <= rsp_valid_d;
      rsp_err_o    <= rsp_err_d;
      rsp_rdata_o  <= rsp_rdata_d;
    end
  end

endmodule
